// File: rtl/sens_power_convert_mc.sv
// Multi-channel sensor power converter: snapshots NCH raw words on start and returns
// clamp(din, LIMIT) * FS / LIMIT per enabled channel through one shared serial divider.
//
// state | meaning
// IDLE  | waiting for data_startp; published results held
// LOAD  | clamp current channel, form x*FS dividend, seed divider
// DIV   | one restoring quotient bit per clock, OUT_W clocks
// STORE | write quotient/clamp to shadow slot; next channel or publish
module sens_power_convert_mc #(
  parameter int NCH   = 4,
  parameter int IN_W  = 16,
  parameter int OUT_W = 10,
  parameter int LIMIT = 3840
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NCH*IN_W-1:0]   pwr_din_i,
  input  logic [NCH-1:0]        ch_en_i,
  input  logic                  data_startp_i,
  output logic [NCH*OUT_W-1:0]  pwr_dout_o,
  output logic [NCH-1:0]        clamp_flag_o,
  output logic                  busy_o,
  output logic                  calc_done_o
);

  localparam int LIM_W = $clog2(LIMIT + 1);
  localparam int ZW    = LIM_W + OUT_W;
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW    = $clog2(OUT_W + 1);
  localparam logic [LIM_W:0] LIM_EXT = (LIM_W + 1)'(LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_STORE} state_t;

  state_t                 state_q, state_d;
  logic [NCH*IN_W-1:0]    din_q, din_d;
  logic [NCH-1:0]         en_q, en_d;
  logic [CHW-1:0]         ch_q, ch_d;
  logic [LIM_W-1:0]       rem_q, rem_d;
  logic [OUT_W-1:0]       zlo_q, zlo_d;
  logic [OUT_W-1:0]       quo_q, quo_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clamp_cur_q, clamp_cur_d;
  logic [NCH*OUT_W-1:0]   res_sh_q, res_sh_d;
  logic [NCH-1:0]         clamp_sh_q, clamp_sh_d;
  logic [NCH*OUT_W-1:0]   dout_q, dout_d;
  logic [NCH-1:0]         cflag_q, cflag_d;
  logic                   done_q, done_d;

  logic [IN_W-1:0]  din_cur;
  logic             over;
  logic [LIM_W-1:0] x_clamped;
  logic [ZW-1:0]    z;
  logic [LIM_W:0]   trial;
  logic             ge;
  logic [CHW:0]     nxt, first;

  // Lowest enabled channel at or above 'from'; MSB of the result flags "found".
  function automatic logic [CHW:0] find_next(input logic [NCH-1:0] mask, input int from);
    find_next = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) find_next = {1'b1, CHW'(i)};
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    din_d       = din_q;
    en_d        = en_q;
    ch_d        = ch_q;
    rem_d       = rem_q;
    zlo_d       = zlo_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    clamp_cur_d = clamp_cur_q;
    res_sh_d    = res_sh_q;
    clamp_sh_d  = clamp_sh_q;
    dout_d      = dout_q;
    cflag_d     = cflag_q;
    done_d      = 1'b0;

    din_cur   = din_q[ch_q*IN_W +: IN_W];
    over      = din_cur > IN_W'(LIMIT);
    x_clamped = over ? LIM_W'(LIMIT) : LIM_W'(din_cur);
    z         = {x_clamped, {OUT_W{1'b0}}} - {{OUT_W{1'b0}}, x_clamped};
    trial     = {rem_q, zlo_q[OUT_W-1]};
    ge        = trial >= LIM_EXT;
    nxt       = find_next(en_q, int'(ch_q) + 1);
    first     = find_next(ch_en_i, 0);

    unique case (state_q)
      S_IDLE: begin
        if (data_startp_i) begin
          din_d      = pwr_din_i;
          en_d       = ch_en_i;
          res_sh_d   = '0;
          clamp_sh_d = '0;
          if (first[CHW]) begin
            ch_d    = first[CHW-1:0];
            state_d = S_LOAD;
          end else begin
            dout_d  = '0;
            cflag_d = '0;
            done_d  = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // Dividend top bits are already below LIMIT, so OUT_W steps give the exact floor.
        rem_d       = z[ZW-1:OUT_W];
        zlo_d       = z[OUT_W-1:0];
        quo_d       = '0;
        cnt_d       = CW'(OUT_W - 1);
        clamp_cur_d = over;
        state_d     = S_DIV;
      end
      S_DIV: begin
        rem_d = ge ? LIM_W'(trial - LIM_EXT) : trial[LIM_W-1:0];
        zlo_d = zlo_q << 1;
        quo_d = (quo_q << 1) | OUT_W'(ge);
        if (cnt_q == '0) state_d = S_STORE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_STORE: begin
        res_sh_d[ch_q*OUT_W +: OUT_W] = quo_q;
        clamp_sh_d[ch_q]              = clamp_cur_q;
        if (nxt[CHW]) begin
          ch_d    = nxt[CHW-1:0];
          state_d = S_LOAD;
        end else begin
          dout_d  = res_sh_d;
          cflag_d = clamp_sh_d;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      din_q       <= '0;
      en_q        <= '0;
      ch_q        <= '0;
      rem_q       <= '0;
      zlo_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      clamp_cur_q <= 1'b0;
      res_sh_q    <= '0;
      clamp_sh_q  <= '0;
      dout_q      <= '0;
      cflag_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      din_q       <= din_d;
      en_q        <= en_d;
      ch_q        <= ch_d;
      rem_q       <= rem_d;
      zlo_q       <= zlo_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      clamp_cur_q <= clamp_cur_d;
      res_sh_q    <= res_sh_d;
      clamp_sh_q  <= clamp_sh_d;
      dout_q      <= dout_d;
      cflag_q     <= cflag_d;
      done_q      <= done_d;
    end
  end

  assign pwr_dout_o   = dout_q;
  assign clamp_flag_o = cflag_q;
  assign busy_o       = (state_q != S_IDLE);
  assign calc_done_o  = done_q;

endmodule

// File: tb/tb_sens_power_convert_mc.sv
// Bench for sens_power_convert_mc: vector table plus scoreboard on the default build,
// and a random sweep on a small build (NCH=2, IN_W=12, OUT_W=8, LIMIT=1000).
module tb_sens_power_convert_mc;
  localparam int NCH = 4, IN_W = 16, OUT_W = 10, LIMIT = 3840, FS = 1023;
  localparam int S_NCH = 2, S_IN = 12, S_OUT = 8, S_LIM = 1000, S_FS = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [NCH*IN_W-1:0]  din;
  logic [NCH-1:0]       en;
  logic                 startp;
  logic [NCH*OUT_W-1:0] dout;
  logic [NCH-1:0]       clamp;
  logic                 busy, done;

  logic [S_NCH*S_IN-1:0]  s_din;
  logic [S_NCH-1:0]       s_en;
  logic                   s_start;
  logic [S_NCH*S_OUT-1:0] s_dout;
  logic [S_NCH-1:0]       s_clamp;
  logic                   s_busy, s_done;

  sens_power_convert_mc dut (
    .clk_i(clk), .rst_ni(rst_n), .pwr_din_i(din), .ch_en_i(en), .data_startp_i(startp),
    .pwr_dout_o(dout), .clamp_flag_o(clamp), .busy_o(busy), .calc_done_o(done)
  );

  sens_power_convert_mc #(.NCH(S_NCH), .IN_W(S_IN), .OUT_W(S_OUT), .LIMIT(S_LIM)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .pwr_din_i(s_din), .ch_en_i(s_en), .data_startp_i(s_start),
    .pwr_dout_o(s_dout), .clamp_flag_o(s_clamp), .busy_o(s_busy), .calc_done_o(s_done)
  );

  typedef struct {
    logic [NCH*OUT_W-1:0] dout;
    logic [NCH-1:0]       clamp;
    int                   lat;
    int                   start_edge;
  } exp_t;

  typedef struct {
    logic [NCH*IN_W-1:0]  din;
    logic [NCH-1:0]       en;
    logic [NCH*OUT_W-1:0] dout;
    logic [NCH-1:0]       clamp;
    int                   lat;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];

  int n_assert = 0, n_fail = 0;
  int edge_n = 0, done_cnt = 0;
  logic rst_seen = 1'b0;
  logic [NCH*OUT_W-1:0] last_dout = '0;
  logic [NCH-1:0]       last_clamp = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [NCH*IN_W-1:0] d, input logic [NCH-1:0] e);
    exp_t r;
    longint x;
    r.dout = '0; r.clamp = '0; r.lat = 0; r.start_edge = 0;
    for (int i = 0; i < NCH; i++) begin
      if (e[i]) begin
        x = longint'(d[i*IN_W +: IN_W]);
        if (x > LIMIT) begin
          x = LIMIT;
          r.clamp[i] = 1'b1;
        end
        r.dout[i*OUT_W +: OUT_W] = OUT_W'((x * FS) / LIMIT);
        r.lat += OUT_W + 2;
      end
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    edge_n++;
    rst_seen = !rst_n;
  end

  // Scoreboard: every calc_done pops one expectation; outputs must hold between dones.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_assert++; n_fail++;
        $display("FAIL unexpected_done: got calc_done=1 expected 0 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("dout", 64'(dout), 64'(e.dout));
        check("clamp", 64'(clamp), 64'(e.clamp));
        check("latency", 64'(edge_n - e.start_edge), 64'(e.lat));
      end
      last_dout = dout; last_clamp = clamp;
    end else if (rst_seen) begin
      last_dout = dout; last_clamp = clamp;
    end else if (dout !== last_dout || clamp !== last_clamp) begin
      check("output_stable", 64'(dout), 64'(last_dout));
      last_dout = dout; last_clamp = clamp;
    end
  end

  task automatic start_run(input logic [NCH*IN_W-1:0] d, input logic [NCH-1:0] e,
                           input logic push, input exp_t x);
    exp_t t;
    t = x;
    t.start_edge = edge_n + 1;
    din = d; en = e; startp = 1'b1;
    if (push) exp_q.push_back(t);
    @(posedge clk); #1;
    startp = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c0;
    bit got;
    c0 = done_cnt; got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk); #1;
      if (done_cnt != c0) got = 1'b1;
    end
    n_assert++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_timeout: got no calc_done expected one within %0d clk", name, budget);
    end
  endtask

  function automatic logic [IN_W-1:0] rnd_word();
    case ($urandom_range(0, 3))
      0: return IN_W'($urandom_range(0, LIMIT));
      1: return IN_W'($urandom_range(LIMIT - 2, LIMIT + 2));
      2: return IN_W'($urandom_range(0, 65535));
      default: return IN_W'($urandom_range(0, 1));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    int   saved;

    vecs[0] = '{din: {16'h0000, 16'h0001, 16'h0780, 16'h0EFF}, en: 4'hF,
                dout: {10'd0, 10'd0, 10'd511, 10'd1022}, clamp: 4'h0, lat: 48};
    vecs[1] = '{din: {16'h0000, 16'h0F01, 16'h0F00, 16'hFFFF}, en: 4'hF,
                dout: {10'd0, 10'd1023, 10'd1023, 10'd1023}, clamp: 4'b0101, lat: 48};
    vecs[2] = '{din: {16'd5000, 16'd100, 16'd1234, 16'd3000}, en: 4'b0101,
                dout: {10'd0, 10'd26, 10'd0, 10'd799}, clamp: 4'h0, lat: 24};
    vecs[3] = '{din: {16'd5000, 16'd100, 16'd1234, 16'd3000}, en: 4'b0000,
                dout: '0, clamp: 4'h0, lat: 0};
    vecs[4] = '{din: {16'd5000, 16'd100, 16'd1234, 16'd3000}, en: 4'b1000,
                dout: {10'd1023, 10'd0, 10'd0, 10'd0}, clamp: 4'b1000, lat: 12};
    vecs[5] = '{din: {16'd0, 16'd3841, 16'd1, 16'd7}, en: 4'b0110,
                dout: {10'd0, 10'd1023, 10'd0, 10'd0}, clamp: 4'b0100, lat: 24};

    rst_n = 1'b0; din = '0; en = '0; startp = 1'b0;
    s_din = '0; s_en = '0; s_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_clamp", 64'(clamp), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      x.dout = vecs[v].dout; x.clamp = vecs[v].clamp; x.lat = vecs[v].lat; x.start_edge = 0;
      start_run(vecs[v].din, vecs[v].en, 1'b1, x);
      check("busy_after_start", 64'(busy), 64'(vecs[v].lat != 0));
      wait_done("vec", vecs[v].lat + 5);
    end

    // Start while busy is dropped; the first run's result is the one published.
    x.dout = vecs[0].dout; x.clamp = vecs[0].clamp; x.lat = 48; x.start_edge = 0;
    start_run(vecs[0].din, vecs[0].en, 1'b1, x);
    repeat (9) @(posedge clk);
    #1;
    check("busy_midrun", 64'(busy), 64'd1);
    start_run(vecs[1].din, vecs[1].en, 1'b0, x);
    wait_done("ignored_start", 60);
    repeat (60) @(posedge clk);
    #1;
    check("busy_after_ignored", 64'(busy), 64'd0);

    // Reset at clk 30 of a run: outputs clear, nothing published.
    x.dout = vecs[1].dout; x.clamp = vecs[1].clamp; x.lat = 48; x.start_edge = 0;
    start_run(vecs[1].din, vecs[1].en, 1'b1, x);
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("midrst_dout", 64'(dout), 64'd0);
    check("midrst_clamp", 64'(clamp), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    saved = done_cnt;
    repeat (60) @(posedge clk);
    #1;
    check("no_done_after_rst", 64'(done_cnt), 64'(saved));
    x.dout = vecs[0].dout; x.clamp = vecs[0].clamp; x.lat = 48; x.start_edge = 0;
    start_run(vecs[0].din, vecs[0].en, 1'b1, x);
    wait_done("restart", 60);

    // Random sweep, each start issued in the previous done cycle.
    for (int n = 0; n < 20; n++) begin
      logic [NCH*IN_W-1:0] d;
      logic [NCH-1:0]      e;
      for (int i = 0; i < NCH; i++) d[i*IN_W +: IN_W] = rnd_word();
      e = NCH'($urandom_range(0, 15));
      x = model(d, e);
      start_run(d, e, 1'b1, x);
      wait_done("rand", x.lat + 5);
    end

    // Small build sweep.
    for (int n = 0; n < 16; n++) begin
      logic [S_NCH*S_OUT-1:0] ed;
      logic [S_NCH-1:0]       ec;
      int el, t0, got_lat;
      longint xv;
      ed = '0; ec = '0; el = 0; got_lat = -1;
      for (int i = 0; i < S_NCH; i++)
        s_din[i*S_IN +: S_IN] = (n % 3 == 0) ? S_IN'($urandom_range(990, 1010))
                                             : S_IN'($urandom_range(0, 4095));
      s_en = S_NCH'($urandom_range(0, 3));
      for (int i = 0; i < S_NCH; i++) begin
        if (s_en[i]) begin
          xv = longint'(s_din[i*S_IN +: S_IN]);
          if (xv > S_LIM) begin xv = S_LIM; ec[i] = 1'b1; end
          ed[i*S_OUT +: S_OUT] = S_OUT'((xv * S_FS) / S_LIM);
          el += S_OUT + 2;
        end
      end
      s_start = 1'b1;
      @(posedge clk);
      t0 = edge_n;
      #1 s_start = 1'b0;
      for (int c = 0; c < 40 && got_lat < 0; c++) begin
        @(negedge clk);
        if (s_done === 1'b1) got_lat = edge_n - t0;
      end
      check("s_latency", 64'(got_lat), 64'(el));
      check("s_dout", 64'(s_dout), 64'(ed));
      check("s_clamp", 64'(s_clamp), 64'(ec));
      @(posedge clk); #1;
    end

    repeat (5) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
